// File: rtl/axil_axi_bridge.sv
// AXI4-Lite slave to AXI4 master bridge.
// Each AXI-Lite access becomes one single-beat INCR AXI4 burst with a fixed ID.
// The write and read paths are independent FSMs, each with one transaction
// outstanding at most. All outputs are registered.
module axil_axi_bridge #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned             ID_WIDTH   = 8,
  parameter logic [ID_WIDTH-1:0]     AXI_ID     = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  // AXI4-Lite write address
  input  logic [ADDR_WIDTH-1:0]  s_axil_awaddr,
  input  logic [2:0]             s_axil_awprot,
  input  logic                   s_axil_awvalid,
  output logic                   s_axil_awready,
  // AXI4-Lite write data
  input  logic [DATA_WIDTH-1:0]  s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]  s_axil_wstrb,
  input  logic                   s_axil_wvalid,
  output logic                   s_axil_wready,
  // AXI4-Lite write response
  output logic [1:0]             s_axil_bresp,
  output logic                   s_axil_bvalid,
  input  logic                   s_axil_bready,
  // AXI4-Lite read address
  input  logic [ADDR_WIDTH-1:0]  s_axil_araddr,
  input  logic [2:0]             s_axil_arprot,
  input  logic                   s_axil_arvalid,
  output logic                   s_axil_arready,
  // AXI4-Lite read data
  output logic [DATA_WIDTH-1:0]  s_axil_rdata,
  output logic [1:0]             s_axil_rresp,
  output logic                   s_axil_rvalid,
  input  logic                   s_axil_rready,
  // AXI4 write address
  output logic [ID_WIDTH-1:0]    m_axi_awid,
  output logic [ADDR_WIDTH-1:0]  m_axi_awaddr,
  output logic [7:0]             m_axi_awlen,
  output logic [2:0]             m_axi_awsize,
  output logic [1:0]             m_axi_awburst,
  output logic                   m_axi_awlock,
  output logic [3:0]             m_axi_awcache,
  output logic [2:0]             m_axi_awprot,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  // AXI4 write data
  output logic [DATA_WIDTH-1:0]  m_axi_wdata,
  output logic [STRB_WIDTH-1:0]  m_axi_wstrb,
  output logic                   m_axi_wlast,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  // AXI4 write response
  input  logic [ID_WIDTH-1:0]    m_axi_bid,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  // AXI4 read address
  output logic [ID_WIDTH-1:0]    m_axi_arid,
  output logic [ADDR_WIDTH-1:0]  m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  output logic                   m_axi_arlock,
  output logic [3:0]             m_axi_arcache,
  output logic [2:0]             m_axi_arprot,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  // AXI4 read data
  input  logic [ID_WIDTH-1:0]    m_axi_rid,
  input  logic [DATA_WIDTH-1:0]  m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready
);

  localparam int unsigned SIZE_VAL = $clog2(STRB_WIDTH);
  localparam logic [2:0]  AXSIZE   = SIZE_VAL[2:0];

  typedef enum logic [1:0] {WR_IDLE, WR_ISSUE, WR_RESP, WR_BRESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA, RD_RESP} rd_state_t;

  wr_state_t             r_wr_state;
  rd_state_t             r_rd_state;

  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [2:0]            r_awprot;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_s_awready;
  logic                  r_s_wready;
  logic                  r_s_bvalid;
  logic [1:0]            r_s_bresp;
  logic                  r_m_awvalid;
  logic                  r_m_wvalid;
  logic                  r_m_bready;

  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [2:0]            r_arprot;
  logic                  r_s_arready;
  logic                  r_s_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_m_arvalid;
  logic                  r_m_rready;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_have;
  logic w_w_have;
  logic w_aw_done;
  logic w_w_done;
  logic [1:0] w_bresp_map;
  logic [1:0] w_rresp_map;

  // Handshake decode and response error mapping
  always_comb begin
    w_aw_hs     = s_axil_awvalid && r_s_awready;
    w_w_hs      = s_axil_wvalid && r_s_wready;
    w_aw_have   = r_aw_held || w_aw_hs;
    w_w_have    = r_w_held || w_w_hs;
    w_aw_done   = !r_m_awvalid || m_axi_awready;
    w_w_done    = !r_m_wvalid || m_axi_wready;
    w_bresp_map = (m_axi_bid != AXI_ID) ? 2'b10 : m_axi_bresp;
    w_rresp_map = ((m_axi_rid != AXI_ID) || !m_axi_rlast) ? 2'b10 : m_axi_rresp;
  end

  // Write path FSM: collect AW and W in any order, issue both, relay B
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state  <= WR_IDLE;
      r_aw_held   <= 1'b0;
      r_w_held    <= 1'b0;
      r_awaddr    <= '0;
      r_awprot    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_s_awready <= 1'b0;
      r_s_wready  <= 1'b0;
      r_s_bvalid  <= 1'b0;
      r_s_bresp   <= '0;
      r_m_awvalid <= 1'b0;
      r_m_wvalid  <= 1'b0;
      r_m_bready  <= 1'b0;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          if (w_aw_hs) begin
            r_awaddr  <= s_axil_awaddr;
            r_awprot  <= s_axil_awprot;
            r_aw_held <= 1'b1;
          end
          if (w_w_hs) begin
            r_wdata  <= s_axil_wdata;
            r_wstrb  <= s_axil_wstrb;
            r_w_held <= 1'b1;
          end
          // Readies are registered, so they must drop in the same edge that
          // completes a capture to avoid accepting a second beat.
          if (w_aw_have && w_w_have) begin
            r_wr_state  <= WR_ISSUE;
            r_m_awvalid <= 1'b1;
            r_m_wvalid  <= 1'b1;
            r_s_awready <= 1'b0;
            r_s_wready  <= 1'b0;
          end else begin
            r_s_awready <= !w_aw_have;
            r_s_wready  <= !w_w_have;
          end
        end
        WR_ISSUE: begin
          if (r_m_awvalid && m_axi_awready) r_m_awvalid <= 1'b0;
          if (r_m_wvalid && m_axi_wready)   r_m_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_wr_state <= WR_RESP;
            r_m_bready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            r_m_bready <= 1'b0;
            r_s_bresp  <= w_bresp_map;
            r_s_bvalid <= 1'b1;
            r_wr_state <= WR_BRESP;
          end
        end
        WR_BRESP: begin
          if (s_axil_bready) begin
            r_s_bvalid  <= 1'b0;
            r_aw_held   <= 1'b0;
            r_w_held    <= 1'b0;
            r_s_awready <= 1'b1;
            r_s_wready  <= 1'b1;
            r_wr_state  <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read path FSM: accept AR, issue AR, capture R, relay R
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state  <= RD_IDLE;
      r_araddr    <= '0;
      r_arprot    <= '0;
      r_s_arready <= 1'b0;
      r_s_rvalid  <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= '0;
      r_m_arvalid <= 1'b0;
      r_m_rready  <= 1'b0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (s_axil_arvalid && r_s_arready) begin
            r_araddr    <= s_axil_araddr;
            r_arprot    <= s_axil_arprot;
            r_s_arready <= 1'b0;
            r_m_arvalid <= 1'b1;
            r_rd_state  <= RD_ADDR;
          end else begin
            r_s_arready <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (m_axi_arready) begin
            r_m_arvalid <= 1'b0;
            r_m_rready  <= 1'b1;
            r_rd_state  <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            r_m_rready <= 1'b0;
            r_rdata    <= m_axi_rdata;
            r_rresp    <= w_rresp_map;
            r_s_rvalid <= 1'b1;
            r_rd_state <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (s_axil_rready) begin
            r_s_rvalid  <= 1'b0;
            r_s_arready <= 1'b1;
            r_rd_state  <= RD_IDLE;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  assign s_axil_awready = r_s_awready;
  assign s_axil_wready  = r_s_wready;
  assign s_axil_bresp   = r_s_bresp;
  assign s_axil_bvalid  = r_s_bvalid;
  assign s_axil_arready = r_s_arready;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;
  assign s_axil_rvalid  = r_s_rvalid;

  assign m_axi_awid     = AXI_ID;
  assign m_axi_awaddr   = r_awaddr;
  assign m_axi_awlen    = 8'd0;
  assign m_axi_awsize   = AXSIZE;
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'b0011;
  assign m_axi_awprot   = r_awprot;
  assign m_axi_awvalid  = r_m_awvalid;
  assign m_axi_wdata    = r_wdata;
  assign m_axi_wstrb    = r_wstrb;
  assign m_axi_wlast    = 1'b1;
  assign m_axi_wvalid   = r_m_wvalid;
  assign m_axi_bready   = r_m_bready;

  assign m_axi_arid     = AXI_ID;
  assign m_axi_araddr   = r_araddr;
  assign m_axi_arlen    = 8'd0;
  assign m_axi_arsize   = AXSIZE;
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'b0011;
  assign m_axi_arprot   = r_arprot;
  assign m_axi_arvalid  = r_m_arvalid;
  assign m_axi_rready   = r_m_rready;

endmodule

// File: tb/tb_axil_axi_bridge.sv
// Directed testbench for axil_axi_bridge: vector table of single
// transactions plus hand-written stall, concurrency and reset sequences.
module tb_axil_axi_bridge;

  localparam logic [7:0] ID = 8'h5A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] s_axil_awaddr = '0;
  logic [2:0]  s_axil_awprot = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [31:0] s_axil_araddr = '0;
  logic [2:0]  s_axil_arprot = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;

  logic [7:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [7:0]  m_axi_bid = '0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [7:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [7:0]  m_axi_rid = '0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;

  int unsigned errors = 0;
  int unsigned checks = 0;

  axil_axi_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .ID_WIDTH   (8),
    .AXI_ID     (ID)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awprot  (s_axil_awprot),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arprot  (s_axil_arprot),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .m_axi_awid     (m_axi_awid),
    .m_axi_awaddr   (m_axi_awaddr),
    .m_axi_awlen    (m_axi_awlen),
    .m_axi_awsize   (m_axi_awsize),
    .m_axi_awburst  (m_axi_awburst),
    .m_axi_awlock   (m_axi_awlock),
    .m_axi_awcache  (m_axi_awcache),
    .m_axi_awprot   (m_axi_awprot),
    .m_axi_awvalid  (m_axi_awvalid),
    .m_axi_awready  (m_axi_awready),
    .m_axi_wdata    (m_axi_wdata),
    .m_axi_wstrb    (m_axi_wstrb),
    .m_axi_wlast    (m_axi_wlast),
    .m_axi_wvalid   (m_axi_wvalid),
    .m_axi_wready   (m_axi_wready),
    .m_axi_bid      (m_axi_bid),
    .m_axi_bresp    (m_axi_bresp),
    .m_axi_bvalid   (m_axi_bvalid),
    .m_axi_bready   (m_axi_bready),
    .m_axi_arid     (m_axi_arid),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arlen    (m_axi_arlen),
    .m_axi_arsize   (m_axi_arsize),
    .m_axi_arburst  (m_axi_arburst),
    .m_axi_arlock   (m_axi_arlock),
    .m_axi_arcache  (m_axi_arcache),
    .m_axi_arprot   (m_axi_arprot),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_rid      (m_axi_rid),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rresp    (m_axi_rresp),
    .m_axi_rlast    (m_axi_rlast),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [1:0]  resp;
    logic [7:0]  id;
    logic        last;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input vec_t v);
    chk("wr_idle_awready", s_axil_awready, 1);
    chk("wr_idle_wready", s_axil_wready, 1);
    s_axil_awaddr = v.addr; s_axil_awprot = v.prot; s_axil_awvalid = 1;
    s_axil_wdata = v.data; s_axil_wstrb = v.strb; s_axil_wvalid = 1;
    m_axi_awready = 1; m_axi_wready = 1;
    tick();
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    chk("wr_awvalid", m_axi_awvalid, 1);
    chk("wr_wvalid", m_axi_wvalid, 1);
    chk("wr_awaddr", m_axi_awaddr, v.addr);
    chk("wr_awprot", m_axi_awprot, v.prot);
    chk("wr_wdata", m_axi_wdata, v.data);
    chk("wr_wstrb", m_axi_wstrb, v.strb);
    chk("wr_wlast", m_axi_wlast, 1);
    chk("wr_awfix", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache},
        {ID, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0011});
    chk("wr_awready_low", s_axil_awready, 0);
    tick();
    chk("wr_awvalid_drop", m_axi_awvalid, 0);
    chk("wr_bready", m_axi_bready, 1);
    m_axi_bvalid = 1; m_axi_bresp = v.resp; m_axi_bid = v.id;
    tick();
    m_axi_bvalid = 0;
    chk("wr_bvalid", s_axil_bvalid, 1);
    chk("wr_bresp", s_axil_bresp, v.exp_resp);
    chk("wr_bready_drop", m_axi_bready, 0);
    s_axil_bready = 1;
    tick();
    s_axil_bready = 0;
    chk("wr_bvalid_drop", s_axil_bvalid, 0);
  endtask

  task automatic do_read(input vec_t v);
    chk("rd_idle_arready", s_axil_arready, 1);
    s_axil_araddr = v.addr; s_axil_arprot = v.prot; s_axil_arvalid = 1;
    m_axi_arready = 1;
    tick();
    s_axil_arvalid = 0;
    chk("rd_arvalid", m_axi_arvalid, 1);
    chk("rd_araddr", m_axi_araddr, v.addr);
    chk("rd_arprot", m_axi_arprot, v.prot);
    chk("rd_arfix", {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache},
        {ID, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0011});
    tick();
    chk("rd_arvalid_drop", m_axi_arvalid, 0);
    chk("rd_rready", m_axi_rready, 1);
    m_axi_rvalid = 1; m_axi_rdata = v.data; m_axi_rresp = v.resp;
    m_axi_rid = v.id; m_axi_rlast = v.last;
    tick();
    m_axi_rvalid = 0;
    chk("rd_rvalid", s_axil_rvalid, 1);
    chk("rd_rdata", s_axil_rdata, v.data);
    chk("rd_rresp", s_axil_rresp, v.exp_resp);
    s_axil_rready = 1;
    tick();
    s_axil_rready = 0;
    chk("rd_rvalid_drop", s_axil_rvalid, 0);
  endtask

  initial begin
    //          wr  addr          data          strb  prot  resp   id     last  exp
    vecs[0] = '{1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 3'd0, 2'b00, ID,    1'b1, 2'b00};
    vecs[1] = '{0, 32'h0000_2004, 32'h1234_5678, 4'h0, 3'd1, 2'b00, ID,    1'b1, 2'b00};
    vecs[2] = '{0, 32'h0000_3000, 32'hA5A5_A5A5, 4'h0, 3'd2, 2'b00, 8'h03, 1'b1, 2'b10};
    vecs[3] = '{1, 32'h0000_4000, 32'h0102_0304, 4'h3, 3'd3, 2'b11, ID,    1'b1, 2'b11};
    vecs[4] = '{1, 32'h8000_0008, 32'hCAFE_F00D, 4'h8, 3'd4, 2'b00, 8'h05, 1'b1, 2'b10};
    vecs[5] = '{0, 32'hFFFF_FFFC, 32'h0BAD_CAFE, 4'h0, 3'd5, 2'b01, ID,    1'b0, 2'b10};
    vecs[6] = '{0, 32'h0000_0010, 32'h5555_AAAA, 4'h0, 3'd6, 2'b01, ID,    1'b1, 2'b01};
    vecs[7] = '{1, 32'h0000_0020, 32'h0000_0001, 4'h1, 3'd7, 2'b10, ID,    1'b1, 2'b10};

    // Reset state
    tick();
    chk("rst_awready", s_axil_awready, 0);
    chk("rst_arready", s_axil_arready, 0);
    chk("rst_valids", {s_axil_bvalid, s_axil_rvalid, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                       m_axi_bready, m_axi_rready}, 0);
    chk("rst_addr", m_axi_awaddr, 0);
    rst = 0;
    chk("rel_awready_still0", s_axil_awready, 0);
    tick();
    chk("rel_readies", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

    // Table-driven single transactions with an always-ready slave
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) do_write(vecs[i]);
      else            do_read(vecs[i]);
    end

    // W two cycles ahead of AW, then AXI4 slave stalls AW/W for 3 cycles
    s_axil_wdata = 32'h0F0F_1234; s_axil_wstrb = 4'hC; s_axil_wvalid = 1;
    m_axi_awready = 0; m_axi_wready = 0;
    tick();
    s_axil_wvalid = 0; s_axil_wdata = '0;
    chk("stl_wready_held", s_axil_wready, 0);
    chk("stl_awready_open", s_axil_awready, 1);
    tick();
    chk("stl_no_issue", m_axi_awvalid, 0);
    s_axil_awaddr = 32'h0000_7000; s_axil_awprot = 3'd2; s_axil_awvalid = 1;
    tick();
    s_axil_awvalid = 0; s_axil_awaddr = '0;
    for (int c = 0; c < 3; c++) begin
      chk("stl_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
      chk("stl_awaddr", m_axi_awaddr, 32'h0000_7000);
      chk("stl_wdata", m_axi_wdata, 32'h0F0F_1234);
      chk("stl_wstrb", m_axi_wstrb, 4'hC);
      tick();
    end
    m_axi_awready = 1; m_axi_wready = 1;
    tick();
    chk("stl_drop", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
    m_axi_bvalid = 1; m_axi_bresp = 2'b00; m_axi_bid = ID;
    tick();
    m_axi_bvalid = 0;
    chk("stl_bvalid", s_axil_bvalid, 1);
    s_axil_bready = 1;
    tick();
    s_axil_bready = 0;
    for (int c = 0; c < 3; c++) begin
      chk("stl_single_b", s_axil_bvalid, 0);
      chk("stl_single_aw", m_axi_awvalid, 0);
      tick();
    end

    // Concurrent read and write, responses held by the AXI-Lite master
    s_axil_awaddr = 32'h0000_5000; s_axil_awvalid = 1;
    s_axil_wdata = 32'h1111_2222; s_axil_wstrb = 4'hF; s_axil_wvalid = 1;
    s_axil_araddr = 32'h0000_6000; s_axil_arvalid = 1;
    m_axi_arready = 1;
    tick();
    s_axil_wvalid = 0;
    chk("cc_issue", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b111);
    chk("cc_readies_low", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
    tick();
    chk("cc_resp_ready", {m_axi_bready, m_axi_rready}, 2'b11);
    m_axi_bvalid = 1; m_axi_bresp = 2'b01; m_axi_bid = ID;
    m_axi_rvalid = 1; m_axi_rdata = 32'h3333_4444; m_axi_rresp = 2'b00;
    m_axi_rid = ID; m_axi_rlast = 1;
    tick();
    m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_bresp = 2'b11;
    for (int c = 0; c < 5; c++) begin
      chk("cc_hold_valid", {s_axil_bvalid, s_axil_rvalid}, 2'b11);
      chk("cc_hold_bresp", s_axil_bresp, 2'b01);
      chk("cc_hold_rdata", s_axil_rdata, 32'h3333_4444);
      chk("cc_no_accept", {s_axil_awready, s_axil_arready, m_axi_awvalid, m_axi_arvalid}, 4'b0000);
      tick();
    end
    s_axil_awvalid = 0; s_axil_arvalid = 0;
    s_axil_bready = 1; s_axil_rready = 1;
    tick();
    s_axil_bready = 0; s_axil_rready = 0;
    chk("cc_release", {s_axil_bvalid, s_axil_rvalid}, 2'b00);
    chk("cc_idle_again", {s_axil_awready, s_axil_arready}, 2'b11);

    // Asynchronous reset while m_axi_arvalid is high
    s_axil_araddr = 32'h0000_9000; s_axil_arvalid = 1; m_axi_arready = 0;
    tick();
    s_axil_arvalid = 0;
    chk("ar_before_rst", m_axi_arvalid, 1);
    #2 rst = 1;
    #1;
    chk("async_arvalid", m_axi_arvalid, 0);
    chk("async_araddr", m_axi_araddr, 0);
    tick();
    rst = 0;
    chk("post_rst_arready0", s_axil_arready, 0);
    tick();
    chk("post_rst_arready1", s_axil_arready, 1);
    chk("post_rst_arvalid", m_axi_arvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
